single_cycle_cpu: RTL and testbench

Board-level top of the processor subsystem, fixed to the GCD application. It receives two unsigned 8-bit operands over UART (8N1, 9600 baud, 50 MHz clock). It computes their greatest common divisor with one Euclid-subtraction step per clock. It returns the result over UART and shows it on the LEDs and a 4-digit multiplexed 7-segment display.

---
 rtl/single_cycle_cpu_pkg.sv | 36 +++
 rtl/single_cycle_cpu_uart_rx.sv | 83 ++++++++
 rtl/single_cycle_cpu.sv | 162 ++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/single_cycle_cpu_pkg.sv
// Shared types, timing defaults and the hex-to-7-segment encoder for the GCD processor top.
package single_cycle_cpu_pkg;

  localparam int CLK_HZ_DEF      = 50000000;
  localparam int BAUD_DEF        = 9600;
  localparam int BIT_CYCLES_DEF  = CLK_HZ_DEF / BAUD_DEF;
  localparam int SCAN_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {WAIT_A, WAIT_B, COMPUTE, SEND} ctrl_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Active-low segments {dp,g,f,e,d,c,b,a}; the decimal point is never lit.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] seg;
    case (v)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/single_cycle_cpu_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-start false-start rejection, stop-bit framing check.
module uart_rx
  import single_cycle_cpu_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam logic [15:0] FULL_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CYCLES / 2 - 1);

  rx_state_t   r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic [7:0]  r_data;
  logic        w_line;

  assign w_line  = r_sync[1];
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (!w_line) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_line ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_line, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_state <= RX_IDLE;
            // A low stop bit is a framing error; the byte is silently dropped.
            if (w_line) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/single_cycle_cpu.sv
// GCD processor top: UART operands in, one Euclid subtraction per clock, result out on UART/LEDs/7-seg.
module single_cycle_cpu
  import single_cycle_cpu_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int BAUD        = BAUD_DEF,
  parameter int SCAN_CYCLES = SCAN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UART_RX,
  input  logic [7:0]  switch,
  output logic        UART_TX,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  localparam int          BIT_CYCLES = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_CYCLES - 1);

  ctrl_state_t r_state, w_state_next;
  logic [7:0]  r_a, r_b, r_led, r_res, r_orig_a, r_pend_data;
  logic        r_pend_valid, r_tx;
  logic [9:0]  r_tx_frame;
  logic [3:0]  r_tx_bit;
  logic [15:0] r_tx_cnt, r_scan_cnt;
  logic        r_scan_on;
  logic [1:0]  r_digit;
  logic        w_rx_valid, w_avail, w_found, w_tx_last;
  logic [7:0]  w_rx_data, w_byte, w_result;
  logic [3:0]  w_nib;
  logic        w_unused_switch;

  assign w_unused_switch = ^switch;

  uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk     (clk),
    .rst_n   (reset),
    .i_rx    (UART_RX),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  always_comb begin
    // The pending byte is older than a byte arriving this cycle, so it is consumed first.
    w_avail      = r_pend_valid | w_rx_valid;
    w_byte       = r_pend_valid ? r_pend_data : w_rx_data;
    w_found      = 1'b0;
    w_result     = r_a;
    w_tx_last    = (r_tx_cnt == BIT_LAST) && (r_tx_bit == 4'd9);
    w_state_next = r_state;
    if (r_a == 8'd0) begin
      w_found  = 1'b1;
      w_result = r_b;
    end else if (r_b == 8'd0 || r_a == r_b) begin
      w_found = 1'b1;
    end
    case (r_state)
      WAIT_A:  if (w_avail) w_state_next = WAIT_B;
      WAIT_B:  if (w_avail) w_state_next = COMPUTE;
      COMPUTE: if (w_found) w_state_next = SEND;
      SEND:    if (w_tx_last) w_state_next = WAIT_A;
      default: w_state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_A;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_led        <= '0;
      r_res        <= '0;
      r_orig_a     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_tx         <= 1'b1;
      r_tx_frame   <= '1;
      r_tx_bit     <= '0;
      r_tx_cnt     <= '0;
    end else begin
      if (r_state == WAIT_A || r_state == WAIT_B) begin
        if (r_pend_valid) begin
          r_pend_valid <= w_rx_valid;
          if (w_rx_valid) r_pend_data <= w_rx_data;
        end
        if (w_avail && r_state == WAIT_A) begin
          r_a      <= w_byte;
          r_orig_a <= w_byte;
        end else if (w_avail) begin
          r_b <= w_byte;
        end
      end else if (w_rx_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= w_rx_data;
      end

      if (r_state == COMPUTE) begin
        if (w_found) begin
          r_led      <= w_result;
          r_res      <= w_result;
          r_tx       <= 1'b0;
          r_tx_frame <= {1'b1, w_result, 1'b0};
          r_tx_bit   <= '0;
          r_tx_cnt   <= '0;
        end else if (r_a > r_b) begin
          r_a <= r_a - r_b;
        end else begin
          r_b <= r_b - r_a;
        end
      end

      if (r_state == SEND) begin
        if (r_tx_cnt == BIT_LAST) begin
          r_tx_cnt <= '0;
          if (r_tx_bit != 4'd9) begin
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx_frame <= {1'b1, r_tx_frame[9:1]};
            r_tx       <= r_tx_frame[1];
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  // The display stays blank for the first scan period, then cycles digit 0..3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      r_scan_on  <= 1'b0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_scan_on  <= 1'b1;
      r_digit    <= r_scan_on ? r_digit + 2'd1 : 2'd0;
    end else begin
      r_scan_cnt <= r_scan_cnt + 16'd1;
    end
  end

  always_comb begin
    w_nib = r_res[3:0];
    case (r_digit)
      2'd1:    w_nib = r_res[7:4];
      2'd2:    w_nib = r_orig_a[3:0];
      2'd3:    w_nib = r_orig_a[7:4];
      default: w_nib = r_res[3:0];
    endcase
  end

  assign digi    = r_scan_on ? {~(4'b0001 << r_digit), hex7(w_nib)} : 12'hFFF;
  assign UART_TX = r_tx;
  assign led     = r_led;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: UART operand pairs in, decoded TX frames checked against a GCD scoreboard.
module tb_single_cycle_cpu;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int SCAN   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        UART_RX = 1'b1;
  wire  [7:0]  switch = 8'bzzzzzzzz;
  logic        UART_TX;
  logic [7:0]  led;
  logic [11:0] digi;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_valid_cyc = 0;

  typedef struct {logic [7:0] res; int steps;} exp_t;
  typedef struct {logic [7:0] data; logic stop; int lat;} obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  single_cycle_cpu #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SCAN_CYCLES(SCAN)) dut (
    .clk     (clk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .switch  (switch),
    .UART_TX (UART_TX),
    .led     (led),
    .digi    (digi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dut.w_rx_valid === 1'b1) last_valid_cyc = cyc;

  // TX frame decoder: samples each bit near its middle and records latency from the last rx_valid.
  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && UART_TX === 1'b0) begin
        o.lat  = cyc - last_valid_cyc;
        o.data = '0;
        repeat (BIT / 2) @(negedge clk);
        if (UART_TX === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            o.data[i] = UART_TX;
          end
          repeat (BIT) @(negedge clk);
          o.stop = UART_TX;
          obs_q.push_back(o);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_le(input string tag, input int obs, input int lim);
    total++;
    assert (obs <= lim) else begin
      bad++;
      $error("FAIL %s observed=%0d expected<=%0d", tag, obs, lim);
    end
  endtask

  function automatic exp_t gcd_model(input logic [7:0] a_in, input logic [7:0] b_in);
    exp_t e;
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    e.steps = 0;
    while (!(a == 0 || b == 0 || a == b)) begin
      if (a > b) a = a - b;
      else       b = b - a;
      e.steps++;
    end
    e.res = (a == 0) ? b : a;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    UART_RX = stop;
    repeat (BIT) @(negedge clk);
    UART_RX = 1'b1;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit push);
    if (push) exp_q.push_back(gcd_model(a, b));
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
  endtask

  task automatic wait_result(input string tag);
    int   n = 0;
    exp_t e;
    obs_t o;
    while (obs_q.size() == 0 && n < 40 * BIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_seen"}, 32'(obs_q.size() != 0), 32'd1);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      $display("%s: tx=0x%02h stop=%0b lat=%0d led=0x%02h expected=0x%02h steps=%0d",
               tag, o.data, o.stop, o.lat, led, e.res, e.steps);
      check({tag, "_tx_data"}, 32'(o.data), 32'(e.res));
      check({tag, "_tx_stop"}, 32'(o.stop), 32'd1);
      check({tag, "_led"}, 32'(led), 32'(e.res));
      check_le({tag, "_latency"}, o.lat, e.steps + 3);
    end
  endtask

  task automatic check_digit(input int d, input logic [7:0] seg);
    int         n = 0;
    logic [3:0] en;
    en = ~(4'b0001 << d);
    while (digi[11:8] !== en && n < 8 * SCAN) begin
      @(negedge clk);
      n++;
    end
    $display("digit%0d: digi=0x%03h", d, digi);
    check($sformatf("digit%0d", d), 32'(digi), 32'({en, seg}));
  endtask

  initial begin
    int n;
    // Reset: outputs must be defined and idle even with switch floating.
    #2 reset = 1'b0;
    #1;
    $display("reset: led=0x%02h tx=%0b digi=0x%03h", led, UART_TX, digi);
    check("rst_led", 32'(led), 32'h00);
    check("rst_tx", 32'(UART_TX), 32'h1);
    check("rst_digi", 32'(digi), 32'hFFF);
    #9 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 32'(UART_TX), 32'h1);
    check("post_rst_digi", 32'(digi), 32'hFFF);

    send_pair(8'h54, 8'h0C, 1'b1);
    wait_result("gcd_54_0c");
    check_digit(3, 8'h92);
    check_digit(2, 8'h99);
    check_digit(1, 8'hC0);
    check_digit(0, 8'hC6);

    send_pair(8'hFF, 8'hFE, 1'b1);
    wait_result("gcd_ff_fe");

    send_pair(8'h00, 8'h00, 1'b1);
    wait_result("gcd_00_00");
    send_pair(8'h00, 8'h07, 1'b1);
    wait_result("gcd_00_07");

    // Short low glitch (false start), then a frame with a low stop bit: neither yields a byte.
    @(negedge clk);
    UART_RX = 1'b0;
    repeat (3) @(negedge clk);
    UART_RX = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_byte(8'h33, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    $display("garbage: tx_frames=%0d led=0x%02h", obs_q.size(), led);
    check("garbage_no_tx", 32'(obs_q.size()), 32'd0);
    check("garbage_led", 32'(led), 32'h07);
    send_pair(8'h06, 8'h04, 1'b1);
    wait_result("gcd_06_04");

    // Reset in the middle of a long computation.
    send_pair(8'hFF, 8'hFE, 1'b0);
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    $display("reset_compute: tx=%0b led=0x%02h digi=0x%03h", UART_TX, led, digi);
    check("rst_compute_tx", 32'(UART_TX), 32'h1);
    check("rst_compute_led", 32'(led), 32'h00);
    check("rst_compute_digi", 32'(digi), 32'hFFF);
    #3 reset = 1'b1;
    repeat (5) @(negedge clk);
    send_pair(8'h0C, 8'h08, 1'b1);
    wait_result("gcd_0c_08");

    // Reset while the start bit of a result is on the line.
    send_pair(8'h54, 8'h0C, 1'b0);
    n = 0;
    while (UART_TX !== 1'b0 && n < 40 * BIT) begin
      @(negedge clk);
      n++;
    end
    check("send_started", 32'(UART_TX), 32'h0);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    $display("reset_send: tx=%0b led=0x%02h", UART_TX, led);
    check("rst_send_tx", 32'(UART_TX), 32'h1);
    check("rst_send_led", 32'(led), 32'h00);
    #3 reset = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    obs_q.delete();
    send_pair(8'h15, 8'h0E, 1'b1);
    wait_result("gcd_15_0e");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
